// File: rtl/hilo_seq.sv
// hilo_seq: MULT sequencer and architectural HI/LO register file.
// Launches the external Booth multiplier, holds its run level until it
// reports stop, then commits the 64-bit product into HI/LO. Also handles
// MTHI/MTLO writes while idle.
// Optional feature: define HILO_TIMEOUT_EN to build a RUN watchdog that
// aborts after TIMEOUT_CYCLES cycles without mult_stop and sets error.
module hilo_seq #(
  parameter int TIMEOUT_CYCLES = 100
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        hi_wr,
  input  logic        lo_wr,
  input  logic [31:0] wr_data,
  output logic        mult_ctrl,
  output logic [31:0] mult_a,
  output logic [31:0] mult_b,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  input  logic        mult_stop,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        ctrl_q, ctrl_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

`ifdef HILO_TIMEOUT_EN
  localparam logic [6:0] TimeoutLast = 7'(TIMEOUT_CYCLES - 1);
  logic [6:0] cnt_q, cnt_d;
  logic       error_q, error_d;
`endif

  // Next-state and next-output logic; commit on stop takes priority over abort
  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef HILO_TIMEOUT_EN
    cnt_d   = cnt_q;
    error_d = error_q;
`endif
    case (state_q)
      IDLE: begin
        if (hi_wr) hi_d = wr_data;
        if (lo_wr) lo_d = wr_data;
        if (start) begin
          a_d     = rs_data;
          b_d     = rt_data;
          ctrl_d  = 1'b1;
          busy_d  = 1'b1;
          state_d = RUN;
`ifdef HILO_TIMEOUT_EN
          cnt_d   = 7'd0;
          error_d = 1'b0;
`endif
        end
      end
      RUN: begin
        if (mult_stop) begin
          hi_d    = mult_hi;
          lo_d    = mult_lo;
          done_d  = 1'b1;
          ctrl_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
`ifdef HILO_TIMEOUT_EN
        else if (cnt_q == TimeoutLast) begin
          error_d = 1'b1;
          ctrl_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        ctrl_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ctrl_q  <= 1'b0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef HILO_TIMEOUT_EN
      cnt_q   <= 7'd0;
      error_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef HILO_TIMEOUT_EN
      cnt_q   <= cnt_d;
      error_q <= error_d;
`endif
    end
  end

  assign mult_ctrl = ctrl_q;
  assign mult_a    = a_q;
  assign mult_b    = b_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef HILO_TIMEOUT_EN
  assign error     = error_q;
`else
  assign error     = 1'b0;
`endif

endmodule

// File: tb/tb_hilo_seq.sv
// Testbench for hilo_seq with a behavioural model of the 32-cycle multiplier.
// Build with HILO_TIMEOUT_EN defined to exercise the watchdog abort path.
module tb_hilo_seq;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        hi_wr;
  logic        lo_wr;
  logic [31:0] wr_data;
  logic        mult_ctrl;
  logic [31:0] mult_a;
  logic [31:0] mult_b;
  logic [31:0] mult_hi;
  logic [31:0] mult_lo;
  logic        mult_stop;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        error;

  int checkCount = 0;
  int failCount  = 0;

  logic [31:0] opA, opB;
  int          mCnt;
  bit          stallMult = 1'b0;

  hilo_seq dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .hi_wr     (hi_wr),
    .lo_wr     (lo_wr),
    .wr_data   (wr_data),
    .mult_ctrl (mult_ctrl),
    .mult_a    (mult_a),
    .mult_b    (mult_b),
    .mult_hi   (mult_hi),
    .mult_lo   (mult_lo),
    .mult_stop (mult_stop),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model: loads at the first edge with ctrl high, writes HI/LO
  // at the 34th such edge and raises stop at the 35th; ctrl low resets it
  always @(posedge clk) begin
    if (!mult_ctrl) begin
      mCnt      <= 0;
      mult_stop <= 1'b0;
    end else begin
      if (mCnt == 0) begin
        opA <= mult_a;
        opB <= mult_b;
      end
      if (mCnt < 60) mCnt <= mCnt + 1;
      if (mCnt == 33)
        {mult_hi, mult_lo} <= 64'(longint'($signed(opA)) * longint'($signed(opB)));
      if (mCnt == 34 && !stallMult) mult_stop <= 1'b1;
    end
  end

  // Safety net so the run always ends
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Issues one MULT and follows it until done (bounded); optionally disturbs
  // the RUN phase with a start/MTHI pulse, or issues MTLO with the start
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input bit disturb, input bit loWr, input logic [31:0] wdata,
                               output int busyCycles, output bit sawDone,
                               output logic [31:0] loAfterStart, output logic [31:0] hiMid);
    rs_data = a;
    rt_data = b;
    start   = 1'b1;
    lo_wr   = loWr;
    wr_data = wdata;
    @(negedge clk);
    start        = 1'b0;
    lo_wr        = 1'b0;
    loAfterStart = lo;
    hiMid        = hi;
    busyCycles   = 0;
    sawDone      = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin
        sawDone = 1'b1;
        break;
      end
      if (busy) busyCycles++;
      if (disturb && i == 5) begin
        start   = 1'b1;
        rs_data = 32'h11;
        rt_data = 32'h22;
        hi_wr   = 1'b1;
        wr_data = 32'hDEADBEEF;
      end
      if (disturb && i == 6) begin
        start = 1'b0;
        hi_wr = 1'b0;
        hiMid = hi;
      end
      @(negedge clk);
    end
  endtask

  int          busyCycles;
  bit          sawDone;
  logic [31:0] loStart;
  logic [31:0] hiMid;
  int          stallBusy;

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    rs_data = 32'd0;
    rt_data = 32'd0;
    hi_wr   = 1'b0;
    lo_wr   = 1'b0;
    wr_data = 32'd0;
    repeat (2) @(negedge clk);

    // Reset state
    checkOutput("rst_hi", hi, 0);
    checkOutput("rst_lo", lo, 0);
    checkOutput("rst_flags", {mult_ctrl, busy, done, error}, 0);
    checkOutput("rst_ops", {mult_a, mult_b}, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // 7 * -3 = -21
    applyStimulus(32'd7, 32'hFFFFFFFD, 1'b0, 1'b0, 32'd0, busyCycles, sawDone, loStart, hiMid);
    checkOutput("t1_done", sawDone, 1);
    checkOutput("t1_busy_cycles", busyCycles, 36);
    checkOutput("t1_busy_at_done", busy, 0);
    checkOutput("t1_hi", hi, 32'hFFFFFFFF);
    checkOutput("t1_lo", lo, 32'hFFFFFFEB);
    @(negedge clk);
    checkOutput("t1_done_pulse", done, 0);
    checkOutput("t1_ctrl_idle", mult_ctrl, 0);

    // (-2^31)^2 = 2^62, then back-to-back 3 * 5
    applyStimulus(32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'd0, busyCycles, sawDone, loStart, hiMid);
    checkOutput("t2_done", sawDone, 1);
    checkOutput("t2_hi", hi, 32'h40000000);
    checkOutput("t2_lo", lo, 32'h00000000);
    checkOutput("t2_ctrl_low", mult_ctrl, 0);
    applyStimulus(32'd3, 32'd5, 1'b0, 1'b0, 32'd0, busyCycles, sawDone, loStart, hiMid);
    checkOutput("t2b_done", sawDone, 1);
    checkOutput("t2b_busy_cycles", busyCycles, 36);
    checkOutput("t2b_hi", hi, 0);
    checkOutput("t2b_lo", lo, 15);

    // -2 * 9 with start and MTHI attempted during RUN
    @(negedge clk);
    applyStimulus(32'hFFFFFFFE, 32'd9, 1'b1, 1'b0, 32'd0, busyCycles, sawDone, loStart, hiMid);
    checkOutput("t3_done", sawDone, 1);
    checkOutput("t3_hi_ignored", hiMid, 0);
    checkOutput("t3_ops_held", {mult_a, mult_b}, {32'hFFFFFFFE, 32'd9});
    checkOutput("t3_hi", hi, 32'hFFFFFFFF);
    checkOutput("t3_lo", lo, 32'hFFFFFFEE);
    @(negedge clk);
    checkOutput("t3_no_relaunch", {busy, mult_ctrl}, 0);

    // MTHI in IDLE, then MTLO together with start of 2 * 3
    hi_wr   = 1'b1;
    wr_data = 32'h12345678;
    @(negedge clk);
    hi_wr = 1'b0;
    checkOutput("t4_mthi", hi, 32'h12345678);
    checkOutput("t4_lo_kept", lo, 32'hFFFFFFEE);
    applyStimulus(32'd2, 32'd3, 1'b0, 1'b1, 32'hCAFEF00D, busyCycles, sawDone, loStart, hiMid);
    checkOutput("t4_mtlo_with_start", loStart, 32'hCAFEF00D);
    checkOutput("t4_done", sawDone, 1);
    checkOutput("t4_hi", hi, 0);
    checkOutput("t4_lo", lo, 6);

    // Reset at edge 10 of RUN, then 6 * 7
    @(negedge clk);
    rs_data = 32'd1;
    rt_data = 32'd1;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    checkOutput("t5_busy_before_rst", busy, 1);
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("t5_rst_flags", {mult_ctrl, busy, done, error}, 0);
    checkOutput("t5_rst_hilo", {hi, lo}, 0);
    checkOutput("t5_rst_ops", {mult_a, mult_b}, 0);
    reset_n = 1'b1;
    @(negedge clk);
    applyStimulus(32'd6, 32'd7, 1'b0, 1'b0, 32'd0, busyCycles, sawDone, loStart, hiMid);
    checkOutput("t5_done", sawDone, 1);
    checkOutput("t5_busy_cycles", busyCycles, 36);
    checkOutput("t5_hi", hi, 0);
    checkOutput("t5_lo", lo, 42);

    // Multiplier never stops
    @(negedge clk);
    stallMult = 1'b1;
    rs_data   = 32'd5;
    rt_data   = 32'd5;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    stallBusy = 0;
`ifdef HILO_TIMEOUT_EN
    for (int i = 0; i < 250; i++) begin
      if (!busy) break;
      stallBusy++;
      @(negedge clk);
    end
    checkOutput("t6_busy_cycles", stallBusy, 100);
    checkOutput("t6_error", error, 1);
    checkOutput("t6_ctrl", mult_ctrl, 0);
    checkOutput("t6_no_done", done, 0);
    checkOutput("t6_hilo_kept", {hi, lo}, {32'd0, 32'd42});
`else
    for (int i = 0; i < 210; i++) begin
      if (busy) stallBusy++;
      @(negedge clk);
    end
    checkOutput("t6_busy_cycles", stallBusy, 210);
    checkOutput("t6_still_busy", {busy, mult_ctrl}, 2'b11);
    checkOutput("t6_error", error, 0);
    checkOutput("t6_hilo_kept", {hi, lo}, {32'd0, 32'd42});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/hilo_seq.md
# hilo_seq

Multiply sequencer and HI/LO register file for the MULT instruction path. It sits between the control unit and the 32-cycle Booth multiplier `mult`. On a one-cycle `start` it captures RS/RT and holds the multiplier's run level high until the multiplier reports `stop`. It then commits the 64-bit product into architectural HI/LO and releases the multiplier. It also services MTHI/MTLO writes and supplies HI/LO to the MFHI/MFLO datapath mux.

## Interface
- `TIMEOUT_CYCLES`, default 100: RUN cycles without `mult_stop` before abort (used only with `HILO_TIMEOUT_EN`).
- `clk`  in  1  system clock, all state on rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `start`  in  1  MULT issue pulse from control unit
- `rs_data`  in  32  multiplicand (RS)
- `rt_data`  in  32  multiplier (RT)
- `hi_wr`  in  1  MTHI write enable
- `lo_wr`  in  1  MTLO write enable
- `wr_data`  in  32  MTHI/MTLO data
- `mult_ctrl`  out  1  run level to multiplier; low resets it
- `mult_a`  out  32  latched multiplicand to multiplier
- `mult_b`  out  32  latched multiplier operand
- `mult_hi`  in  32  multiplier HI result
- `mult_lo`  in  32  multiplier LO result
- `mult_stop`  in  1  multiplier completion level
- `hi`  out  32  architectural HI
- `lo`  out  32  architectural LO
- `busy`  out  1  high while state is RUN; control unit stalls on it
- `done`  out  1  one-cycle pulse on commit
- `error`  out  1  sticky timeout flag

## Operation
- All outputs are registered.
- Reset (`reset_n`=0 at an edge): state IDLE. `mult_ctrl`, `mult_a`, `mult_b`, `hi`, `lo`, `busy`, `done` and `error` all become 0. Reset overrides every other input.
- States: IDLE, RUN.
- IDLE, `start`=1:
  - `mult_a`<=`rs_data`, `mult_b`<=`rt_data`, `mult_ctrl`<=1, `busy`<=1.
  - `error`<=0, state<=RUN.
- IDLE, `hi_wr`/`lo_wr`=1: `hi`/`lo`<=`wr_data`.
  - Both enables set: both registers load.
  - A write in the same cycle as `start` is applied; the later commit overwrites it.
- RUN:
  - `start`, `hi_wr` and `lo_wr` are ignored.
  - `mult_a`/`mult_b` are held stable.
  - At the first edge with `mult_stop`=1: `hi`<=`mult_hi`, `lo`<=`mult_lo`, `done`<=1, `mult_ctrl`<=0, `busy`<=0, state<=IDLE.
- `done` is high for exactly one cycle and is 0 at every other edge.
- Product width is 64 bits, signed; HI is bits 63:32. No arithmetic occurs in this block; it is pure transfer.
- Back-to-back: a `start` in the cycle right after `done` is legal. `mult_ctrl` is then low for exactly one sampled edge, which resets the multiplier before relaunch.

## Timing
- `start` sampled at edge 0; `mult_ctrl`=1 from edge 0.
- The multiplier loads at edge 1, shifts at edges 2–33, writes its HI/LO at edge 34 and raises `stop` at edge 35.
- Commit happens at edge 36: `hi`/`lo` are valid and `done`=1 in the cycle after edge 36.
- `busy` is high from edge 0 through edge 36 (36 cycles).
- MTHI/MTLO: value visible on `hi`/`lo` the cycle after the write edge.
- Reset mid-RUN: `mult_ctrl` drops at the reset edge, so the multiplier self-resets at the next edge. The partial result is discarded.

## Configuration
- `HILO_TIMEOUT_EN` defined:
  - A 7-bit counter clears on entry to RUN and increments each RUN cycle.
  - If it reaches `TIMEOUT_CYCLES` with `mult_stop`=0: `error`<=1, `mult_ctrl`<=0, `busy`<=0, state<=IDLE.
  - On abort, `done` stays 0 and `hi`/`lo` are unchanged.
  - If `mult_stop`=1 arrives on that same edge, the commit wins.
- Not defined: no counter is built, `error` is tied 0, and RUN waits indefinitely for `mult_stop`.

## Test plan
- After reset: start with `rs_data`=7, `rt_data`=0xFFFFFFFD -> `done` after edge 36; `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB; `busy` high for 36 cycles.
- Start with `rs_data`=0x80000000, `rt_data`=0x80000000 -> `hi`=0x40000000, `lo`=0x00000000. Then start again the cycle after `done` with 3×5 -> `hi`=0, `lo`=15 after another 36 cycles.
- During RUN, pulse `start` with new operands and `hi_wr` with 0xDEADBEEF -> both ignored; `mult_a`/`mult_b` unchanged; committed product is from the original operands.
- IDLE, `hi_wr`=1 with `wr_data`=0x12345678 -> `hi`=0x12345678 next cycle, `lo` unchanged. Then `lo_wr`+`start` in the same cycle -> `lo` takes `wr_data`, later overwritten at commit.
- `reset_n`=0 at edge 10 of RUN -> every output reads 0 the following cycle. A new start of 6×7 completes in 36 cycles with `lo`=42.
- Bench model holds `mult_stop`=0:
  - With `HILO_TIMEOUT_EN`: `error`=1 and `busy`=0 after 100 RUN cycles; `hi`/`lo` unchanged.
  - Without it: `busy` stays 1 for 200+ cycles.
